// File: rtl/note_voice_scheduler_if.sv
// Key-to-speaker bundle for the shared tone divider: raw key levels in,
// square-wave drive and note status out.
interface note_voice_scheduler_if;
  logic [7:0] keys;
  logic       tone;
  logic       playing;
  logic [2:0] note_idx;
  logic       note_change;

  modport master (
    output keys,
    input  tone,
    input  playing,
    input  note_idx,
    input  note_change
  );

  modport slave (
    input  keys,
    output tone,
    output playing,
    output note_idx,
    output note_change
  );
endinterface

// File: rtl/note_voice_scheduler.sv
// One square-wave divider shared by eight keys (C4..C5) with last-pressed priority;
// the divider is only retuned at half-period boundaries so no runt pulses reach the speaker.
module note_voice_scheduler #(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 17,
  parameter int F0     = 262,
  parameter int F1     = 294,
  parameter int F2     = 330,
  parameter int F3     = 349,
  parameter int F4     = 392,
  parameter int F5     = 440,
  parameter int F6     = 494,
  parameter int F7     = 523
) (
  input  logic                  clk,
  input  logic                  reset,
  note_voice_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam int FREQ [8] = '{F0, F1, F2, F3, F4, F5, F6, F7};

  logic [CNT_W-1:0] half_tbl [8];

  // Half-period counts are elaboration-time constants; only a mux remains in hardware.
  for (genvar gi = 0; gi < 8; gi++) begin : g_half
    assign half_tbl[gi] = CNT_W'((CLK_HZ / 2) / FREQ[gi]);
  end

  function automatic logic [2:0] highest_idx(input logic [7:0] v);
    highest_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) highest_idx = 3'(i);
    end
  endfunction

  logic [7:0]       s1_q, s2_q, prev_q;
  logic [7:0]       press;
  logic [2:0]       target_q, target_d;
  logic             target_valid_q, target_valid_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_run, n_cur;
  logic             tone_q, tone_d, tone_run;
  logic [2:0]       note_idx_q, note_idx_d;
  logic             note_change_q, note_change_d;
  logic             toggle;

  assign press = s2_q & ~prev_q;

  always_comb begin
    target_d       = target_q;
    target_valid_d = target_valid_q;
    if (|press) begin
      target_d       = highest_idx(press);
      target_valid_d = 1'b1;
    end else if (!target_valid_q || !s2_q[target_q]) begin
      // Current key let go: fall back to the highest key still held.
      if (|s2_q) begin
        target_d       = highest_idx(s2_q);
        target_valid_d = 1'b1;
      end else begin
        target_valid_d = 1'b0;
      end
    end
  end

  assign n_cur    = half_tbl[note_idx_q];
  assign toggle   = (cnt_q == n_cur - 1'b1);
  assign cnt_run  = toggle ? '0 : cnt_q + 1'b1;
  assign tone_run = toggle ? ~tone_q : tone_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tone_d        = tone_q;
    note_idx_d    = note_idx_q;
    note_change_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (target_valid_q) begin
          state_d       = PLAY;
          note_idx_d    = target_q;
          tone_d        = 1'b1;
          note_change_d = 1'b1;
        end
      end
      PLAY: begin
        cnt_d  = cnt_run;
        tone_d = tone_run;
        if (!target_valid_q) begin
          state_d = STOP;
        end else if (toggle && (target_q != note_idx_q)) begin
          note_idx_d    = target_q;
          note_change_d = 1'b1;
        end
      end
      STOP: begin
        // A high half-period is finished at the current pitch before going silent.
        if (target_valid_q) begin
          state_d = PLAY;
          cnt_d   = cnt_run;
          tone_d  = tone_run;
        end else if (!tone_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          tone_d  = 1'b0;
        end else begin
          cnt_d  = cnt_run;
          tone_d = tone_run;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q           <= '0;
      s2_q           <= '0;
      prev_q         <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      tone_q         <= 1'b0;
      note_idx_q     <= '0;
      note_change_q  <= 1'b0;
    end else begin
      s1_q           <= bus.keys;
      s2_q           <= s1_q;
      prev_q         <= s2_q;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tone_q         <= tone_d;
      note_idx_q     <= note_idx_d;
      note_change_q  <= note_change_d;
    end
  end

  assign bus.tone        = tone_q;
  assign bus.playing     = (state_q != IDLE);
  assign bus.note_idx    = note_idx_q;
  assign bus.note_change = note_change_q;

endmodule
